// File: rtl/reg_file_multiport.sv
// Multi-port register file: NUM_READ combinational read ports, an ALU write port,
// a byte-masked load-return write port, a load scoreboard and a HI/LO pair.

module reg_file_read_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0] stored,
  input  logic                  stored_pending,
  input  logic                  wr0_valid,
  input  logic [ADDR_WIDTH-1:0] wr0_reg,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  input  logic                  wr1_valid,
  input  logic [ADDR_WIDTH-1:0] wr1_reg,
  input  logic [DATA_WIDTH-1:0] wr1_merged,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  pending
);
  logic wr0_hit, wr1_hit;

  assign wr0_hit = BYPASS && wr0_valid && (wr0_reg == index);
  assign wr1_hit = BYPASS && wr1_valid && (wr1_reg == index);

  always_comb begin
    data    = stored;
    pending = stored_pending;
    if (wr0_hit) data = wr0_data;
    // wr1_merged already carries port 0 lanes when both ports target this register
    if (wr1_hit) begin
      data    = wr1_merged;
      pending = 1'b0;
    end
    if (index == '0) begin
      data    = '0;
      pending = 1'b0;
    end
  end
endmodule

module reg_file_multiport #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_READ    = 2,
  parameter bit BYPASS      = 1,
  parameter int DEBUG_INDEX = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_index,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]            read_pending,
  input  logic                           wr0_enable,
  input  logic [ADDR_WIDTH-1:0]          wr0_reg,
  input  logic [DATA_WIDTH-1:0]          wr0_data,
  input  logic                           wr1_enable,
  input  logic [ADDR_WIDTH-1:0]          wr1_reg,
  input  logic [DATA_WIDTH-1:0]          wr1_data,
  input  logic [DATA_WIDTH/8-1:0]        wr1_byte_en,
  input  logic                           reserve_enable,
  input  logic [ADDR_WIDTH-1:0]          reserve_reg,
  input  logic                           hilo_enable,
  input  logic [DATA_WIDTH-1:0]          hi_data,
  input  logic [DATA_WIDTH-1:0]          lo_data,
  output logic [DATA_WIDTH-1:0]          hi_out,
  output logic [DATA_WIDTH-1:0]          lo_out,
  output logic [DATA_WIDTH-1:0]          debug_reg
);
  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH/8;

  if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
    $error("reg_file_multiport: NUM_READ must be in 1..4");
  end
  if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("reg_file_multiport: DATA_WIDTH must be a positive multiple of 8");
  end
  if (DEBUG_INDEX < 0 || DEBUG_INDEX >= DEPTH) begin : g_bad_debug
    $error("reg_file_multiport: DEBUG_INDEX out of range");
  end

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DATA_WIDTH-1:0] hi_q, lo_q;

  logic                  wr0_valid, wr1_valid, reserve_valid;
  logic [DATA_WIDTH-1:0] wr1_base, wr1_merged;

  assign wr0_valid     = wr0_enable && (wr0_reg != '0);
  // A load return with no enabled lanes neither writes nor clears the scoreboard
  assign wr1_valid     = wr1_enable && (wr1_reg != '0) && (wr1_byte_en != '0);
  assign reserve_valid = reserve_enable && (reserve_reg != '0);

  assign wr1_base = (wr0_valid && wr0_reg == wr1_reg) ? wr0_data : regs[wr1_reg];

  always_comb begin
    wr1_merged = wr1_base;
    for (int b = 0; b < NBYTES; b++)
      if (wr1_byte_en[b]) wr1_merged[b*8 +: 8] = wr1_data[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      regs[0] <= '0;
      pend[0] <= 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
        if (wr0_valid && wr0_reg == ADDR_WIDTH'(i)) regs[i] <= wr0_data;
        if (wr1_valid && wr1_reg == ADDR_WIDTH'(i)) regs[i] <= wr1_merged;
        // set after clear: a fresh reservation outlives the returning load
        if (wr1_valid && wr1_reg == ADDR_WIDTH'(i)) pend[i] <= 1'b0;
        if (reserve_valid && reserve_reg == ADDR_WIDTH'(i)) pend[i] <= 1'b1;
      end
      if (hilo_enable) begin
        hi_q <= hi_data;
        lo_q <= lo_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] data;
    logic                  pending;
    assign idx = read_index[k*ADDR_WIDTH +: ADDR_WIDTH];

    reg_file_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BYPASS    (BYPASS)
    ) u_port (
      .index         (idx),
      .stored        (regs[idx]),
      .stored_pending(pend[idx]),
      .wr0_valid     (wr0_valid),
      .wr0_reg       (wr0_reg),
      .wr0_data      (wr0_data),
      .wr1_valid     (wr1_valid),
      .wr1_reg       (wr1_reg),
      .wr1_merged    (wr1_merged),
      .data          (data),
      .pending       (pending)
    );

    assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
    assign read_pending[k]                       = pending;
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

  if (DEBUG_INDEX == 0) begin : g_dbg_zero
    assign debug_reg = '0;
  end else begin : g_dbg
    assign debug_reg = regs[DEBUG_INDEX];
  end
endmodule

// File: tb/tb_reg_file_multiport.sv
// Directed bench: a bypassing and a non-bypassing instance share all inputs.
module tb_reg_file_multiport;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  idx0, idx1;
  logic           wr0_enable, wr1_enable, reserve_enable, hilo_enable;
  logic [AW-1:0]  wr0_reg, wr1_reg, reserve_reg;
  logic [DW-1:0]  wr0_data, wr1_data, hi_data, lo_data;
  logic [3:0]     wr1_byte_en;

  logic [NR*DW-1:0] rd_b, rd_n;
  logic [NR-1:0]    pend_b, pend_n;
  logic [DW-1:0]    hi_b, lo_b, dbg_b, hi_n, lo_n, dbg_n;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_file_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1), .DEBUG_INDEX(2)) u_byp (
    .clk(clk), .reset(reset), .read_index({idx1, idx0}), .read_data(rd_b), .read_pending(pend_b),
    .wr0_enable(wr0_enable), .wr0_reg(wr0_reg), .wr0_data(wr0_data),
    .wr1_enable(wr1_enable), .wr1_reg(wr1_reg), .wr1_data(wr1_data), .wr1_byte_en(wr1_byte_en),
    .reserve_enable(reserve_enable), .reserve_reg(reserve_reg),
    .hilo_enable(hilo_enable), .hi_data(hi_data), .lo_data(lo_data),
    .hi_out(hi_b), .lo_out(lo_b), .debug_reg(dbg_b));

  reg_file_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(0), .DEBUG_INDEX(2)) u_nobyp (
    .clk(clk), .reset(reset), .read_index({idx1, idx0}), .read_data(rd_n), .read_pending(pend_n),
    .wr0_enable(wr0_enable), .wr0_reg(wr0_reg), .wr0_data(wr0_data),
    .wr1_enable(wr1_enable), .wr1_reg(wr1_reg), .wr1_data(wr1_data), .wr1_byte_en(wr1_byte_en),
    .reserve_enable(reserve_enable), .reserve_reg(reserve_reg),
    .hilo_enable(hilo_enable), .hi_data(hi_data), .lo_data(lo_data),
    .hi_out(hi_n), .lo_out(lo_n), .debug_reg(dbg_n));

  task automatic idle();
    reset = 0; wr0_enable = 0; wr1_enable = 0; reserve_enable = 0; hilo_enable = 0;
    wr0_reg = '0; wr1_reg = '0; reserve_reg = '0;
    wr0_data = '0; wr1_data = '0; wr1_byte_en = '0; hi_data = '0; lo_data = '0;
  endtask

  // rising edge, then release all write/reserve controls and settle
  task automatic edge_and_idle();
    @(posedge clk); #1; idle(); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); reset = 1; idx0 = 5'd5; idx1 = 5'd0;
    edge_and_idle();
    vectors++; if ({rd_b, rd_n} !== '0) begin miscompares++; $display("FAIL reset_read got %h/%h want 0", rd_b, rd_n); end
    vectors++; if ({pend_b, pend_n} !== '0) begin miscompares++; $display("FAIL reset_pend got %b/%b want 0", pend_b, pend_n); end
    vectors++; if ({hi_b, lo_b, dbg_b, hi_n, lo_n, dbg_n} !== '0) begin miscompares++; $display("FAIL reset_hilo_dbg got %h %h %h want 0", hi_b, lo_b, dbg_b); end
  endtask

  task automatic test_write_read();
    @(negedge clk); idx0 = 5'd5; wr0_enable = 1; wr0_reg = 5'd5; wr0_data = 32'h12345678; #1;
    vectors++; if (rd_b[DW-1:0] !== 32'h12345678) begin miscompares++; $display("FAIL wr0_bypass got %h want 12345678", rd_b[DW-1:0]); end
    vectors++; if (rd_n[DW-1:0] !== 32'h0) begin miscompares++; $display("FAIL wr0_nobypass got %h want 00000000", rd_n[DW-1:0]); end
    edge_and_idle();
    vectors++; if (rd_b[DW-1:0] !== 32'h12345678 || rd_n[DW-1:0] !== 32'h12345678) begin miscompares++; $display("FAIL wr0_stored got %h/%h want 12345678", rd_b[DW-1:0], rd_n[DW-1:0]); end
  endtask

  task automatic test_byte_merge();
    @(negedge clk); idx0 = 5'd7; wr0_enable = 1; wr0_reg = 5'd7; wr0_data = 32'hAABBCCDD;
    edge_and_idle();
    @(negedge clk); wr1_enable = 1; wr1_reg = 5'd7; wr1_data = 32'h11223344; wr1_byte_en = 4'b0011; #1;
    vectors++; if (rd_b[DW-1:0] !== 32'hAABB3344 || rd_n[DW-1:0] !== 32'hAABBCCDD) begin miscompares++; $display("FAIL merge_comb got %h/%h want AABB3344/AABBCCDD", rd_b[DW-1:0], rd_n[DW-1:0]); end
    edge_and_idle();
    vectors++; if (rd_n[DW-1:0] !== 32'hAABB3344) begin miscompares++; $display("FAIL merge_stored got %h want AABB3344", rd_n[DW-1:0]); end
  endtask

  task automatic test_both_ports();
    @(negedge clk); idx1 = 5'd9;
    wr0_enable = 1; wr0_reg = 5'd9; wr0_data = 32'hFFFFFFFF;
    wr1_enable = 1; wr1_reg = 5'd9; wr1_data = 32'h00000000; wr1_byte_en = 4'b1000; #1;
    vectors++; if (rd_b[2*DW-1:DW] !== 32'h00FFFFFF) begin miscompares++; $display("FAIL both_bypass got %h want 00FFFFFF", rd_b[2*DW-1:DW]); end
    edge_and_idle();
    vectors++; if (rd_n[2*DW-1:DW] !== 32'h00FFFFFF) begin miscompares++; $display("FAIL both_stored got %h want 00FFFFFF", rd_n[2*DW-1:DW]); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk); idx0 = 5'd4; reserve_enable = 1; reserve_reg = 5'd4; #1;
    vectors++; if (pend_b[0] !== 1'b0) begin miscompares++; $display("FAIL reserve_pre got %b want 0", pend_b[0]); end
    edge_and_idle();
    vectors++; if (pend_b[0] !== 1'b1 || pend_n[0] !== 1'b1) begin miscompares++; $display("FAIL reserve_set got %b/%b want 1", pend_b[0], pend_n[0]); end
    @(negedge clk); wr0_enable = 1; wr0_reg = 5'd4; wr0_data = 32'h0000BEEF;
    edge_and_idle();
    vectors++; if (pend_n[0] !== 1'b1) begin miscompares++; $display("FAIL wr0_keeps_pend got %b want 1", pend_n[0]); end
    @(negedge clk); wr1_enable = 1; wr1_reg = 5'd4; wr1_data = 32'h44444444; wr1_byte_en = 4'b1111; #1;
    vectors++; if (pend_b[0] !== 1'b0 || pend_n[0] !== 1'b1) begin miscompares++; $display("FAIL clear_comb got %b/%b want 0/1", pend_b[0], pend_n[0]); end
    edge_and_idle();
    vectors++; if (pend_n[0] !== 1'b0 || rd_n[DW-1:0] !== 32'h44444444) begin miscompares++; $display("FAIL clear_done got %b %h want 0 44444444", pend_n[0], rd_n[DW-1:0]); end
    @(negedge clk); reserve_enable = 1; reserve_reg = 5'd4;
    edge_and_idle();
    @(negedge clk); reserve_enable = 1; reserve_reg = 5'd4;
    wr1_enable = 1; wr1_reg = 5'd4; wr1_data = 32'h0; wr1_byte_en = 4'b1111;
    edge_and_idle();
    vectors++; if (pend_n[0] !== 1'b1 || pend_b[0] !== 1'b1) begin miscompares++; $display("FAIL reserve_and_clear got %b/%b want 1", pend_b[0], pend_n[0]); end
  endtask

  task automatic test_reg0_hilo();
    @(negedge clk); idx0 = 5'd0; wr0_enable = 1; wr0_reg = 5'd0; wr0_data = 32'hDEADBEEF;
    reserve_enable = 1; reserve_reg = 5'd0; hilo_enable = 1; hi_data = 32'h1; lo_data = 32'h2; #1;
    vectors++; if (rd_b[DW-1:0] !== 32'h0) begin miscompares++; $display("FAIL r0_bypass got %h want 0", rd_b[DW-1:0]); end
    edge_and_idle();
    vectors++; if (rd_b[DW-1:0] !== 32'h0 || pend_b[0] !== 1'b0 || pend_n[0] !== 1'b0) begin miscompares++; $display("FAIL r0_stored got %h %b want 0 0", rd_b[DW-1:0], pend_b[0]); end
    vectors++; if (hi_b !== 32'h1 || lo_b !== 32'h2) begin miscompares++; $display("FAIL hilo got %h/%h want 1/2", hi_b, lo_b); end
    @(negedge clk); hi_data = 32'h77; lo_data = 32'h88;
    edge_and_idle();
    vectors++; if (hi_b !== 32'h1 || lo_b !== 32'h2) begin miscompares++; $display("FAIL hilo_hold got %h/%h want 1/2", hi_b, lo_b); end
  endtask

  task automatic test_reset_override();
    @(negedge clk); wr0_enable = 1; wr0_reg = 5'd2; wr0_data = 32'hCAFEF00D; #1;
    vectors++; if (dbg_b !== 32'h0) begin miscompares++; $display("FAIL debug_not_bypassed got %h want 0", dbg_b); end
    edge_and_idle();
    vectors++; if (dbg_b !== 32'hCAFEF00D) begin miscompares++; $display("FAIL debug_load got %h want CAFEF00D", dbg_b); end
    @(negedge clk); idx0 = 5'd2; idx1 = 5'd3; reserve_enable = 1; reserve_reg = 5'd3;
    edge_and_idle();
    vectors++; if (pend_n[1] !== 1'b1) begin miscompares++; $display("FAIL r3_reserved got %b want 1", pend_n[1]); end
    @(negedge clk); reset = 1; wr0_enable = 1; wr0_reg = 5'd2; wr0_data = 32'h5;
    reserve_enable = 1; reserve_reg = 5'd3; hilo_enable = 1; hi_data = 32'h9; lo_data = 32'h9;
    edge_and_idle();
    vectors++; if (dbg_b !== '0 || dbg_n !== '0) begin miscompares++; $display("FAIL reset_debug got %h want 0", dbg_b); end
    vectors++; if ({rd_b, rd_n} !== '0 || {pend_b, pend_n} !== '0) begin miscompares++; $display("FAIL reset_override got %h %b want 0", rd_b, pend_b); end
    vectors++; if ({hi_b, lo_b} !== '0) begin miscompares++; $display("FAIL reset_hilo got %h/%h want 0", hi_b, lo_b); end
    @(negedge clk); wr1_enable = 1; wr1_reg = 5'd3; wr1_data = 32'h00000055; wr1_byte_en = 4'b0001;
    edge_and_idle();
    vectors++; if (rd_n[2*DW-1:DW] !== 32'h55 || pend_n[1] !== 1'b0) begin miscompares++; $display("FAIL post_reset_load got %h %b want 00000055 0", rd_n[2*DW-1:DW], pend_n[1]); end
  endtask

  initial begin
    idle(); idx0 = '0; idx1 = '0;
    test_reset();
    test_write_read();
    test_byte_merge();
    test_both_ports();
    test_scoreboard();
    test_reg0_hilo();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
